serial_ripple_subtractor: RTL

//   Bit-serial unsigned subtractor: d = a - b - bin, one bit per clock, LSB first, through a single
//   1-bit full subtractor with a registered ripple borrow. Inverse-direction companion to the

---
 rtl/serial_ripple_subtractor_pkg.sv | 15 +
 rtl/full_subtractor.sv | 24 ++
 rtl/serial_ripple_subtractor.sv | 104 ++++++++++
 3 files changed

// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial ripple subtractor.
package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Bit index counter width; never narrower than one bit.
  function automatic int count_width(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Gate-level 1-bit full subtractor: d = a ^ b ^ bin, bout = (~a & b) | (~(a ^ b) & bin).
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  wire w_axb;
  wire w_na;
  wire w_naxb;
  wire w_t1;
  wire w_t2;

  xor u_x1 (w_axb, a, b);
  xor u_x2 (d, w_axb, bin);
  not u_n1 (w_na, a);
  not u_n2 (w_naxb, w_axb);
  and u_a1 (w_t1, w_na, b);
  and u_a2 (w_t2, w_naxb, bin);
  or  u_o1 (bout, w_t1, w_t2);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial unsigned subtractor d = a - b - bin, LSB first, one bit per clock,
// with valid/ready handshakes on both sides.
module serial_ripple_subtractor
  import subtractor_pkg::*;
#(
  parameter int bit_width = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [bit_width-1:0] a,
  input  logic [bit_width-1:0] b,
  input  logic                 bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [bit_width-1:0] d,
  output logic                 bout
);

  localparam int CW = count_width(bit_width);
  localparam logic [CW-1:0] LAST_BIT = CW'(bit_width - 1);

  sub_state_t           r_state;
  logic [CW-1:0]        r_count;
  logic [bit_width-1:0] r_a;
  logic [bit_width-1:0] r_b;
  logic [bit_width-2:0] r_acc;
  logic                 r_borrow;
  logic [bit_width-1:0] r_d;
  logic                 r_bout;
  logic                 r_out_valid;

  wire                  w_diff;
  wire                  w_borrow_next;
  logic [bit_width-1:0] w_shift;

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .d    (w_diff),
    .bout (w_borrow_next)
  );

  // Newest difference bit enters at the MSB; on the last bit this is the full result.
  assign w_shift = {w_diff, r_acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_borrow    <= 1'b0;
      r_d         <= '0;
      r_bout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_count  <= '0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_acc    <= w_shift[bit_width-1:1];
          r_borrow <= w_borrow_next;
          if (r_count == LAST_BIT) begin
            r_d         <= w_shift;
            r_bout      <= w_borrow_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign d         = r_d;
  assign bout      = r_bout;

endmodule
